// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP sequencer: FSM state encoding and the
// default lane width, lane count and psum memory address width.
package sfp_pkg;

  localparam int unsigned DefPsumBw = 16;
  localparam int unsigned DefCol    = 8;
  localparam int unsigned DefAddrBw = 11;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRead,
    StDrain,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/sfp_relu.sv
// One-lane signed clamp.
// Ports: relu_en - clamp enable; din - signed lane value; dout - din, or 0 when
// relu_en is set and din is negative.
module sfp_relu #(
  parameter int unsigned psum_bw = 16
) (
  input  logic               relu_en,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout
);

  always_comb begin
    dout = din;
    if (relu_en && din[psum_bw-1]) begin
      dout = '0;
    end
  end

endmodule

// File: rtl/sfp_seq.sv
// Sequencer that accumulates k_len psum vectors per output vector through an
// external sfp accumulator bank and writes n_vec (optionally ReLU-clamped)
// results back to psum memory.
// Ports: clk/reset (sync, active-high); start plus job parameters k_len, n_vec,
// base_addr, stride, out_addr, relu_en; memory read port mem_rd_en/addr/data;
// accumulator control acc_clr/acc_in/acc_valid and result acc_out; memory
// write port mem_wr_en/addr/data; status busy and done.
module sfp_seq
  import sfp_pkg::*;
#(
  parameter int unsigned psum_bw = DefPsumBw,
  parameter int unsigned col     = DefCol,
  parameter int unsigned addr_bw = DefAddrBw
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             k_len,
  input  logic [3:0]             n_vec,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [addr_bw-1:0]     stride,
  input  logic [addr_bw-1:0]     out_addr,
  input  logic                   relu_en,
  output logic                   mem_rd_en,
  output logic [addr_bw-1:0]     mem_rd_addr,
  input  logic [col*psum_bw-1:0] mem_rd_data,
  output logic                   acc_clr,
  output logic [col*psum_bw-1:0] acc_in,
  output logic                   acc_valid,
  input  logic [col*psum_bw-1:0] acc_out,
  output logic                   mem_wr_en,
  output logic [addr_bw-1:0]     mem_wr_addr,
  output logic [col*psum_bw-1:0] mem_wr_data,
  output logic                   busy,
  output logic                   done
);

  state_e state_q, state_d;

  logic [3:0]         k_q, n_q, pass_q, vec_q;
  logic [addr_bw-1:0] stride_q, vec_base_q, rd_addr_q, wr_addr_q;
  logic               relu_q, rd_en_q;
  logic [col*psum_bw-1:0] relu_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (n_vec == 4'd0) ? StDone : StClear;
        end
      end
      StClear: state_d = (k_q != 4'd0) ? StRead : StWrite;
      StRead:  state_d = (pass_q == k_q - 4'd1) ? StDrain : StRead;
      StDrain: state_d = StWrite;
      StWrite: state_d = ({1'b0, vec_q} + 5'd1 < {1'b0, n_q}) ? StClear : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Job parameters, pass/vector counters and address pointers.
  // vec_base_q tracks base_addr + v so each vector restarts its read walk there.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q        <= '0;
      n_q        <= '0;
      stride_q   <= '0;
      relu_q     <= 1'b0;
      pass_q     <= '0;
      vec_q      <= '0;
      vec_base_q <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_en_q    <= 1'b0;
    end else begin
      rd_en_q <= (state_q == StRead);
      case (state_q)
        StIdle: begin
          if (start) begin
            k_q        <= k_len;
            n_q        <= n_vec;
            stride_q   <= stride;
            relu_q     <= relu_en;
            pass_q     <= '0;
            vec_q      <= '0;
            vec_base_q <= base_addr;
            rd_addr_q  <= base_addr;
            wr_addr_q  <= out_addr;
          end
        end
        StRead: begin
          rd_addr_q <= rd_addr_q + stride_q;
          pass_q    <= pass_q + 4'd1;
        end
        StWrite: begin
          pass_q     <= '0;
          vec_q      <= vec_q + 4'd1;
          vec_base_q <= vec_base_q + addr_bw'(1);
          rd_addr_q  <= vec_base_q + addr_bw'(1);
          wr_addr_q  <= wr_addr_q + addr_bw'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_relu
    sfp_relu #(
      .psum_bw(psum_bw)
    ) u_relu (
      .relu_en(relu_q),
      .din    (acc_out[i*psum_bw +: psum_bw]),
      .dout   (relu_data[i*psum_bw +: psum_bw])
    );
  end

  assign acc_in = mem_rd_data;

  // Outputs; reset is applied combinationally so the strobes drop in the very
  // cycle reset is high, keeping them exclusive with the forced acc_clr.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    acc_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    acc_clr     = reset || (state_q == StClear);
    if (!reset) begin
      acc_valid = rd_en_q;
      busy      = (state_q != StIdle) && (state_q != StDone);
      done      = (state_q == StDone);
      if (state_q == StRead) begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = rd_addr_q;
      end
      if (state_q == StWrite) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = wr_addr_q;
        mem_wr_data = relu_data;
      end
    end
  end

endmodule

// File: tb/tb_sfp_seq.sv
module tb_sfp_seq;

  localparam int unsigned W = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    k_len = '0, n_vec = '0;
  logic [10:0]   base_addr = '0, stride = '0, out_addr = '0;
  logic          relu_en = 1'b0;
  logic          mem_rd_en, acc_clr, acc_valid, mem_wr_en, busy, done;
  logic [10:0]   mem_rd_addr, mem_wr_addr;
  logic [W-1:0]  mem_rd_data = '0, acc_in, acc_out = '0, mem_wr_data;

  logic [W-1:0]  mem [0:2047];
  logic [10:0]   rd_log[$];
  logic [10:0]   wr_a_log[$];
  logic [W-1:0]  wr_d_log[$];
  int            done_cnt = 0;
  int            excl_viol = 0;
  int            n_checks = 0;
  int            n_err = 0;
  int            cyc;

  sfp_seq u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k_len      (k_len),
    .n_vec      (n_vec),
    .base_addr  (base_addr),
    .stride     (stride),
    .out_addr   (out_addr),
    .relu_en    (relu_en),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .acc_clr    (acc_clr),
    .acc_in     (acc_in),
    .acc_valid  (acc_valid),
    .acc_out    (acc_out),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Psum memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // External accumulator bank: eight 16-bit lanes
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (acc_clr) acc_out[i*16 +: 16] <= '0;
      else if (acc_valid) acc_out[i*16 +: 16] <= acc_out[i*16 +: 16] + acc_in[i*16 +: 16];
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_log.push_back(mem_rd_addr);
    if (mem_wr_en) begin
      wr_a_log.push_back(mem_wr_addr);
      wr_d_log.push_back(mem_wr_data);
    end
    if (done) done_cnt++;
    if (acc_clr && (mem_rd_en || mem_wr_en || acc_valid)) excl_viol++;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_a_log.delete();
    wr_d_log.delete();
    done_cnt = 0;
  endtask

  // Runs one job; cycles counts rising edges from the start-sampling edge
  // up to and including the edge that enters DONE.
  task automatic run_job(input string tag, input logic [3:0] k, input logic [3:0] n,
                         input logic [10:0] b, input logic [10:0] s, input logic [10:0] o,
                         input logic r, input int dup_at, output int cycles);
    logic got;
    clear_logs();
    @(negedge clk);
    k_len = k; n_vec = n; base_addr = b; stride = s; out_addr = o; relu_en = r;
    start = 1'b1;
    cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = (cycles == dup_at);
      // Scramble the inputs to prove the latched copies are used.
      k_len = 4'hf; n_vec = 4'hf; base_addr = 11'h555; stride = 11'h2aa; out_addr = 11'h123;
      relu_en = ~r;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, " done seen"}, W'(got), W'(1));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[0]    = {8{16'd5}};
    mem[16]   = {8{16'd5}};
    mem[32]   = {8{16'd5}};
    mem[200]  = {4{16'd4, 16'hfffe}};
    mem[201]  = {4{16'd5, 16'hfffe}};
    mem[2040] = {8{16'd1}};
    mem[2044] = {8{16'd2}};
    mem[2041] = {8{16'd10}};
    mem[2045] = {8{16'd20}};
    mem[700]  = {8{16'd7}};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst busy", W'(busy), W'(0));
    check_eq("rst done", W'(done), W'(0));
    check_eq("rst rd_en", W'(mem_rd_en), W'(0));
    check_eq("rst wr_en", W'(mem_wr_en), W'(0));
    check_eq("rst acc_valid", W'(acc_valid), W'(0));
    check_eq("rst acc_clr", W'(acc_clr), W'(1));
    reset = 1'b0;
    #1;
    check_eq("idle acc_clr", W'(acc_clr), W'(0));
    check_eq("idle rd_addr", W'(mem_rd_addr), W'(0));

    // k=3, n=1: three reads, lanes sum to 15
    run_job("basic", 4'd3, 4'd1, 11'd0, 11'd16, 11'd100, 1'b0, 0, cyc);
    check_eq("basic cycles", W'(cyc), W'(7));
    check_eq("basic nrd", W'(rd_log.size()), W'(3));
    check_eq("basic rd0", W'(rd_log[0]), W'(0));
    check_eq("basic rd1", W'(rd_log[1]), W'(16));
    check_eq("basic rd2", W'(rd_log[2]), W'(32));
    check_eq("basic nwr", W'(wr_a_log.size()), W'(1));
    check_eq("basic wr addr", W'(wr_a_log[0]), W'(100));
    check_eq("basic wr data", wr_d_log[0], {8{16'd15}});

    // ReLU on/off with lanes summing to -4 and +9
    run_job("relu on", 4'd2, 4'd1, 11'd200, 11'd1, 11'd300, 1'b1, 0, cyc);
    check_eq("relu on cycles", W'(cyc), W'(6));
    check_eq("relu on data", wr_d_log[0], {4{16'd9, 16'd0}});
    run_job("relu off", 4'd2, 4'd1, 11'd200, 11'd1, 11'd300, 1'b0, 0, cyc);
    check_eq("relu off data", wr_d_log[0], {4{16'd9, 16'hfffc}});

    // Address wrap-around on reads and writes
    run_job("wrap", 4'd2, 4'd2, 11'd2040, 11'd4, 11'd2047, 1'b0, 0, cyc);
    check_eq("wrap cycles", W'(cyc), W'(11));
    check_eq("wrap nrd", W'(rd_log.size()), W'(4));
    check_eq("wrap rd0", W'(rd_log[0]), W'(2040));
    check_eq("wrap rd1", W'(rd_log[1]), W'(2044));
    check_eq("wrap rd2", W'(rd_log[2]), W'(2041));
    check_eq("wrap rd3", W'(rd_log[3]), W'(2045));
    check_eq("wrap nwr", W'(wr_a_log.size()), W'(2));
    check_eq("wrap wr0 addr", W'(wr_a_log[0]), W'(2047));
    check_eq("wrap wr1 addr", W'(wr_a_log[1]), W'(0));
    check_eq("wrap wr0 data", wr_d_log[0], {8{16'd3}});
    check_eq("wrap wr1 data", wr_d_log[1], {8{16'd30}});

    // n_vec = 0: no memory traffic
    run_job("n0", 4'd3, 4'd0, 11'd0, 11'd16, 11'd100, 1'b0, 0, cyc);
    check_eq("n0 cycles", W'(cyc), W'(1));
    check_eq("n0 nrd", W'(rd_log.size()), W'(0));
    check_eq("n0 nwr", W'(wr_a_log.size()), W'(0));

    // k_len = 0: a single write of zeros
    run_job("k0", 4'd0, 4'd1, 11'd0, 11'd16, 11'd400, 1'b0, 0, cyc);
    check_eq("k0 cycles", W'(cyc), W'(3));
    check_eq("k0 nrd", W'(rd_log.size()), W'(0));
    check_eq("k0 nwr", W'(wr_a_log.size()), W'(1));
    check_eq("k0 wr addr", W'(wr_a_log[0]), W'(400));
    check_eq("k0 wr data", wr_d_log[0], W'(0));

    // Reset in the middle of a k=4 read burst
    clear_logs();
    @(negedge clk);
    k_len = 4'd4; n_vec = 4'd1; base_addr = 11'd500; stride = 11'd1; out_addr = 11'd600;
    relu_en = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_eq("abort in read", W'(mem_rd_en), W'(1));
    reset = 1'b1;
    #1;
    check_eq("abort rd_en", W'(mem_rd_en), W'(0));
    check_eq("abort acc_valid", W'(acc_valid), W'(0));
    check_eq("abort acc_clr", W'(acc_clr), W'(1));
    check_eq("abort busy", W'(busy), W'(0));
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("abort idle busy", W'(busy), W'(0));
    check_eq("abort idle acc_clr", W'(acc_clr), W'(0));
    repeat (10) @(negedge clk);
    check_eq("abort nwr", W'(wr_a_log.size()), W'(0));
    check_eq("abort ndone", W'(done_cnt), W'(0));
    run_job("post abort", 4'd1, 4'd1, 11'd700, 11'd3, 11'd710, 1'b0, 0, cyc);
    check_eq("post abort cycles", W'(cyc), W'(5));
    check_eq("post abort wr addr", W'(wr_a_log[0]), W'(710));
    check_eq("post abort wr data", wr_d_log[0], {8{16'd7}});

    // Second start while busy is ignored
    run_job("dup", 4'd1, 4'd1, 11'd700, 11'd3, 11'd720, 1'b0, 2, cyc);
    repeat (10) @(negedge clk);
    check_eq("dup cycles", W'(cyc), W'(5));
    check_eq("dup ndone", W'(done_cnt), W'(1));
    check_eq("dup nwr", W'(wr_a_log.size()), W'(1));

    check_eq("clr exclusive", W'(excl_viol), W'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
